rr_arb_mux: RTL
===============

# rr_arb_mux

Parametrised N-channel, W-bit arbitrating multiplexer with valid/ready handshakes on every input and a registered output stage. It replaces the fixed 4:1 one-hot combinational mux with a sequential block that selects one requesting channel per cycle by fixed priority, round-robin, or a forced one-hot select, and holds the selected beat until the consumer accepts it. It sits between several producer channels and a single shared downstream consumer.

## Interface
- N_CH, 4, number of input channels (>= 2)
- W, 8, data width in bits
- IW, $clog2(N_CH), channel index width (derived, not overridden)

- clk_i  in  1  clock; all state updates on rising edge
- rst_i  in  1  reset, synchronous, active-high
- mode_i  in  2  00 fixed priority, 01 round-robin, 10 forced select, 11 treated as 00
- sel_i  in  N_CH  one-hot forced select, used only in mode 10
- in_valid_i  in  N_CH  per-channel valid
- in_data_i  in  N_CH*W  channel k data at bits [k*W +: W]
- in_ready_o  out  N_CH  per-channel ready; at most one bit set
- out_valid_o  out  1  output register holds a beat
- out_ready_i  in  1  consumer accepts beat
- out_data_o  out  W  registered data
- out_ch_o  out  IW  source channel of the registered beat
- sel_err_o  out  1  mode 10 with sel_i not one-hot (combinational)

## Operation
- load = in_valid_i[g] & (~out_valid_o | out_ready_i), where g is the winner below; no winner -> no load.
- Winner g:
  - mode 00/11: lowest index k with in_valid_i[k].
  - mode 01: first k with in_valid_i[k], searching ptr, ptr+1, ..., wrapping mod N_CH.
  - mode 10: index of the single set bit of sel_i, valid only if in_valid_i[that bit]. Zero or multiple bits set -> no winner, sel_err_o=1.
- in_ready_o[g] = 1 only when load is 1 for g; all other bits are 0. in_ready_o is combinational from in_valid_i, mode_i, sel_i, ptr, out_valid_o and out_ready_i.
- On load: out_data_o <= in_data_i[g], out_ch_o <= g, out_valid_o <= 1.
- On out_valid_o & out_ready_i without load: out_valid_o <= 0. out_data_o and out_ch_o hold their last value.
- Round-robin pointer ptr (IW bits) is updated only on load in mode 01, to g+1, wrapping N_CH-1 -> 0. It is not touched in other modes and is retained across mode changes.
- Output register contents are stable while out_valid_o=1 and out_ready_i=0.
- Changing mode_i mid-stream takes effect on the same cycle's arbitration. A beat already registered is unaffected.
- A dropped in_valid_i without handshake is legal. The channel simply loses arbitration.

## Timing
- Reset (rst_i=1 at edge): out_valid_o=0, out_data_o=0, out_ch_o=0, ptr=0. in_ready_o then reads all-zero until the next valid request. Reset overrides a simultaneous load. A beat held at reset is discarded.
- Latency: input handshake in cycle t -> beat on out_* in cycle t+1.
- Throughput: 1 beat/cycle with out_ready_i held 1. Simultaneous drain and load in the same cycle is required: no bubble.
- Backpressure: out_valid_o=1 and out_ready_i=0 -> in_ready_o=0, no state change.
- ptr wrap: grant to channel N_CH-1 in mode 01 -> ptr=0 next cycle.

## Test plan
- Reset: hold rst_i 2 cycles with all in_valid_i=1 -> out_valid_o=0, out_data_o=0x00, out_ch_o=0, in_ready_o=0000 during reset. First grant after release goes to ch0 in mode 01.
- Fixed priority: N_CH=4, data ch0..3 = 0x10..0x13, all valid, mode 00, out_ready_i=1 -> out_data_o=0x10, out_ch_o=0 every cycle from cycle 1. in_ready_o=0001.
- Round-robin: same stimulus, mode 01 -> out_ch_o sequence 0,1,2,3,0,1 on consecutive cycles, data 0x10,0x11,0x12,0x13,0x10. With only ch1 and ch3 valid -> 1,3,1,3.
- Backpressure: out_ready_i=0 for 3 cycles while holding 0x11 -> out_data_o=0x11 stable, in_ready_o=0000, ptr unchanged. Raising out_ready_i gives the next beat with no bubble.
- Forced select: mode 10, sel_i=0100, all valid -> only ch2 (0x12) transfers, sel_err_o=0. Then sel_i=0110 or 0000 -> no load, out_valid_o drops after drain, sel_err_o=1.
- Reset mid-stream: assert rst_i in mode 01 with ptr=2 and out_valid_o=1, out_ready_i=0 -> next cycle out_valid_o=0 and ptr=0. Next grant goes to ch0.

Source files
------------

// File: rtl/rr_arb_mux_if.sv
// rr_arb_mux_if: handshake bundle between N_CH producers, the arbiter and one consumer.
//   mode_i      - arbitration mode (00 fixed, 01 round-robin, 10 forced, 11 = 00)
//   sel_i       - one-hot forced select (mode 10 only)
//   in_valid_i  - per-channel valid
//   in_data_i   - packed channel data, channel k at [k*W +: W]
//   in_ready_o  - per-channel ready, at most one bit set
//   out_valid_o - output register holds a beat
//   out_ready_i - consumer accepts the beat
//   out_data_o  - registered data
//   out_ch_o    - source channel of the registered beat
//   sel_err_o   - forced mode with a non one-hot select
// The slave modport is the arbiter's view; master is the surrounding logic.
interface rr_arb_mux_if #(
    parameter int unsigned N_CH = 4,
    parameter int unsigned W    = 8
);
    localparam int unsigned IW = (N_CH > 1) ? $clog2(N_CH) : 1;

    logic [1:0]        mode_i;
    logic [N_CH-1:0]   sel_i;
    logic [N_CH-1:0]   in_valid_i;
    logic [N_CH*W-1:0] in_data_i;
    logic [N_CH-1:0]   in_ready_o;
    logic              out_valid_o;
    logic              out_ready_i;
    logic [W-1:0]      out_data_o;
    logic [IW-1:0]     out_ch_o;
    logic              sel_err_o;

    modport master (
        output mode_i, sel_i, in_valid_i, in_data_i, out_ready_i,
        input  in_ready_o, out_valid_o, out_data_o, out_ch_o, sel_err_o
    );

    modport slave (
        input  mode_i, sel_i, in_valid_i, in_data_i, out_ready_i,
        output in_ready_o, out_valid_o, out_data_o, out_ch_o, sel_err_o
    );
endinterface

// File: rtl/rr_arb_mux.sv
// rr_arb_mux: N_CH-channel, W-bit arbitrating mux with a registered output stage.
// Picks one requesting channel per cycle (fixed priority, round-robin or forced
// one-hot select) and holds the beat until the consumer takes it.
//   clk_i - clock, rising edge
//   rst_i - synchronous active-high reset
//   bus   - rr_arb_mux_if.slave handshake bundle (see interface header)
module rr_arb_mux #(
    parameter int unsigned N_CH = 4,
    parameter int unsigned W    = 8
) (
    input  logic         clk_i,
    input  logic         rst_i,
    rr_arb_mux_if.slave  bus
);
    localparam int unsigned IW = (N_CH > 1) ? $clog2(N_CH) : 1;

    logic              out_valid_q;
    logic [W-1:0]      out_data_q;
    logic [IW-1:0]     out_ch_q;
    logic [IW-1:0]     ptr_q;

    logic              win_vld;
    logic [IW-1:0]     win_idx;
    logic [W-1:0]      win_data;
    logic              sel_err;
    logic              load;
    logic [N_CH-1:0]   in_ready;
    logic [IW-1:0]     ptr_nxt;
    logic [IW-1:0]     rr_idx;
    int                rr_pos;

    // Winner selection, load decision and grant vector.
    always_comb begin
        win_vld  = 1'b0;
        win_idx  = '0;
        win_data = '0;
        sel_err  = 1'b0;
        in_ready = '0;
        rr_pos   = 0;
        rr_idx   = '0;

        case (bus.mode_i)
            2'b01: begin
                // Walk offsets high to low so the nearest requester after ptr wins.
                for (int i = int'(N_CH) - 1; i >= 0; i--) begin
                    rr_pos = int'(ptr_q) + i;
                    if (rr_pos >= int'(N_CH)) rr_pos = rr_pos - int'(N_CH);
                    rr_idx = IW'(rr_pos);
                    if (bus.in_valid_i[rr_idx]) begin
                        win_vld = 1'b1;
                        win_idx = rr_idx;
                    end
                end
            end
            2'b10: begin
                sel_err = ~$onehot(bus.sel_i);
                if (!sel_err) begin
                    for (int k = 0; k < int'(N_CH); k++) begin
                        if (bus.sel_i[k]) begin
                            win_idx = IW'(k);
                            win_vld = bus.in_valid_i[k];
                        end
                    end
                end
            end
            default: begin
                // Descending scan: lowest valid index is assigned last.
                for (int k = int'(N_CH) - 1; k >= 0; k--) begin
                    if (bus.in_valid_i[k]) begin
                        win_vld = 1'b1;
                        win_idx = IW'(k);
                    end
                end
            end
        endcase

        for (int k = 0; k < int'(N_CH); k++) begin
            if (IW'(k) == win_idx) win_data = bus.in_data_i[k*W +: W];
        end

        // Reset blocks any handshake so nothing is lost while held in reset.
        load = ~rst_i & win_vld & (~out_valid_q | bus.out_ready_i);
        if (load) in_ready[win_idx] = 1'b1;

        ptr_nxt = (win_idx == IW'(N_CH - 1)) ? '0 : win_idx + IW'(1);
    end

    // Output register and round-robin pointer.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_ch_q    <= '0;
            ptr_q       <= '0;
        end else begin
            if (load) begin
                out_valid_q <= 1'b1;
                out_data_q  <= win_data;
                out_ch_q    <= win_idx;
                if (bus.mode_i == 2'b01) ptr_q <= ptr_nxt;
            end else if (out_valid_q && bus.out_ready_i) begin
                out_valid_q <= 1'b0;
            end
        end
    end

    assign bus.in_ready_o  = in_ready;
    assign bus.out_valid_o = out_valid_q;
    assign bus.out_data_o  = out_data_q;
    assign bus.out_ch_o    = out_ch_q;
    assign bus.sel_err_o   = sel_err;
endmodule
